// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A-compatible PIC: OCW2 command codes,
// acknowledge-sequencer states and level-width constants.
package pic_pkg;

  localparam int LVL_W  = 3;
  localparam int NUM_IR = 8;

  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NSEOI        = 3'b001;
  localparam logic [2:0] OCW2_SEOI         = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NSEOI    = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [2:0] OCW2_ROT_SEOI     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK1 = 2'd1,
    ST_ACK2 = 2'd2
  } state_t;

  function automatic logic [NUM_IR-1:0] levelMask(input logic [LVL_W-1:0] lvl);
    return NUM_IR'(1) << lvl;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating-priority resolver: scans levels from lp+1 down to lp and returns the
// first requesting level that is not shadowed by an equal-or-higher ISR bit.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] i_req,
  input  logic [NUM_IR-1:0] i_isr,
  input  logic [LVL_W-1:0]  i_lp,
  output logic              o_pending,
  output logic [LVL_W-1:0]  o_winner
);

  logic [LVL_W-1:0] w_lvl;
  logic             w_blocked;

  // An in-service level stops the scan, so only strictly higher requests win.
  always_comb begin
    o_pending = 1'b0;
    o_winner  = LVL_W'(7);
    w_blocked = 1'b0;
    w_lvl     = '0;
    for (int k = 0; k < NUM_IR; k++) begin
      w_lvl = i_lp + LVL_W'(k + 1);
      if (!o_pending && !w_blocked) begin
        if (i_isr[w_lvl]) begin
          w_blocked = 1'b1;
        end else if (i_req[w_lvl]) begin
          o_pending = 1'b1;
          o_winner  = w_lvl;
        end
      end
    end
  end

endmodule

// File: rtl/pic_interrupt_sequencer.sv
// Interrupt arbiter and two-pulse INTA sequencer for the PIC: owns the ISR,
// EOI processing, the rotating priority pointer and the vector output.
module pic_interrupt_sequencer
  import pic_pkg::*;
#(
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       irr,
  input  logic [7:0]       imr,
  input  logic [4:0]       vec_base,
  input  logic             aeoi,
  input  logic             inta_n,
  input  logic             eoi_valid,
  input  logic [2:0]       eoi_cmd,
  input  logic [2:0]       eoi_level,
  output logic             int_out,
  output logic [7:0]       irr_clr,
  output logic [VEC_W-1:0] data_out,
  output logic             data_oe,
  output logic [7:0]       isr
);

  state_t           r_state, w_stateNext;
  logic             r_intaPrev, r_intOut, r_dataOe, r_rotAeoi, w_rotAeoiNext;
  logic [7:0]       r_irrClr, r_isr, w_isrSet, w_isrClr;
  logic [VEC_W-1:0] r_dataOut;
  logic [LVL_W-1:0] r_lp, r_winner, w_lpNext, w_winner, w_isrTop;
  logic             w_pending, w_isrAny, w_intaFall, w_intaRise;
  logic             w_ack1Entry, w_ack2Entry, w_ack2Exit;

  assign w_intaFall  = r_intaPrev & ~inta_n;
  assign w_intaRise  = ~r_intaPrev & inta_n;
  assign w_ack1Entry = (r_state == ST_IDLE) && w_intaFall;
  assign w_ack2Entry = (r_state == ST_ACK1) && w_intaFall;
  assign w_ack2Exit  = (r_state == ST_ACK2) && w_intaRise;

  pic_priority_resolver u_arbiter (
    .i_req     (irr & ~imr),
    .i_isr     (r_isr),
    .i_lp      (r_lp),
    .o_pending (w_pending),
    .o_winner  (w_winner)
  );

  // Same resolver with no nesting finds the highest-priority in-service level.
  pic_priority_resolver u_eoiLookup (
    .i_req     (r_isr),
    .i_isr     (8'h00),
    .i_lp      (r_lp),
    .o_pending (w_isrAny),
    .o_winner  (w_isrTop)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: if (w_intaFall) w_stateNext = ST_ACK1;
      ST_ACK1: if (w_intaFall) w_stateNext = ST_ACK2;
      ST_ACK2: if (w_intaRise) w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // EOI commands are evaluated after the AEOI update so they win on lp.
  always_comb begin
    w_isrSet      = '0;
    w_isrClr      = '0;
    w_lpNext      = r_lp;
    w_rotAeoiNext = r_rotAeoi;
    if (w_ack1Entry && w_pending) w_isrSet = levelMask(w_winner);
    if (w_ack2Exit && aeoi) begin
      w_isrClr = levelMask(r_winner);
      if (r_rotAeoi) w_lpNext = r_winner;
    end
    if (eoi_valid) begin
      case (eoi_cmd)
        OCW2_NSEOI:        if (w_isrAny) w_isrClr = w_isrClr | levelMask(w_isrTop);
        OCW2_ROT_NSEOI: begin
          if (w_isrAny) begin
            w_isrClr = w_isrClr | levelMask(w_isrTop);
            w_lpNext = w_isrTop;
          end
        end
        OCW2_SEOI:         w_isrClr = w_isrClr | levelMask(eoi_level);
        OCW2_ROT_SEOI: begin
          w_isrClr = w_isrClr | levelMask(eoi_level);
          w_lpNext = eoi_level;
        end
        OCW2_SET_PRIO:     w_lpNext = eoi_level;
        OCW2_ROT_AEOI_SET: w_rotAeoiNext = 1'b1;
        OCW2_ROT_AEOI_CLR: w_rotAeoiNext = 1'b0;
        default:           ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_intaPrev <= 1'b1;
      r_intOut   <= 1'b0;
      r_irrClr   <= '0;
      r_dataOut  <= '0;
      r_dataOe   <= 1'b0;
      r_isr      <= '0;
      r_lp       <= LVL_W'(7);
      r_winner   <= LVL_W'(7);
      r_rotAeoi  <= 1'b0;
    end else begin
      r_intaPrev <= inta_n;
      r_intOut   <= (r_state == ST_IDLE) && !w_intaFall && w_pending;
      r_irrClr   <= (w_ack1Entry && w_pending) ? levelMask(w_winner) : 8'h00;
      r_isr      <= (r_isr | w_isrSet) & ~w_isrClr;
      r_lp       <= w_lpNext;
      r_rotAeoi  <= w_rotAeoiNext;
      if (w_ack1Entry) r_winner <= w_winner;
      if (w_ack2Entry) begin
        r_dataOut <= VEC_W'({vec_base, r_winner});
        r_dataOe  <= 1'b1;
      end else if (w_ack2Exit) begin
        r_dataOe  <= 1'b0;
      end
    end
  end

  assign int_out  = r_intOut;
  assign irr_clr  = r_irrClr;
  assign data_out = r_dataOut;
  assign data_oe  = r_dataOe;
  assign isr      = r_isr;

endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
// Directed scoreboard bench for pic_interrupt_sequencer: expectations are queued
// as each step is driven and checked one clock later.
module tb_pic_interrupt_sequencer;

  localparam int F_INT  = 0;
  localparam int F_CLR  = 1;
  localparam int F_DOUT = 2;
  localparam int F_OE   = 3;
  localparam int F_ISR  = 4;

  typedef struct {
    string      tag;
    int         field;
    logic [7:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, aeoi, inta_n, eoi_valid;
  logic [7:0] irr, imr;
  logic [4:0] vec_base;
  logic [2:0] eoi_cmd, eoi_level;
  logic       int_out, data_oe;
  logic [7:0] irr_clr, data_out, isr;

  exp_t sb[$];
  int   tests    = 0;
  int   failures = 0;

  pic_interrupt_sequencer #(.VEC_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .irr       (irr),
    .imr       (imr),
    .vec_base  (vec_base),
    .aeoi      (aeoi),
    .inta_n    (inta_n),
    .eoi_valid (eoi_valid),
    .eoi_cmd   (eoi_cmd),
    .eoi_level (eoi_level),
    .int_out   (int_out),
    .irr_clr   (irr_clr),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .isr       (isr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] observe(input int field);
    case (field)
      F_INT:   return {7'b0, int_out};
      F_CLR:   return irr_clr;
      F_DOUT:  return data_out;
      F_OE:    return {7'b0, data_oe};
      default: return isr;
    endcase
  endfunction

  task automatic expectOut(input string tag, input int field, input logic [7:0] val);
    exp_t e;
    e.tag   = tag;
    e.field = field;
    e.val   = val;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] irrV, input logic intaV,
                               input logic eoiV, input logic [2:0] cmd,
                               input logic [2:0] lvl);
    irr       = irrV;
    inta_n    = intaV;
    eoi_valid = eoiV;
    eoi_cmd   = cmd;
    eoi_level = lvl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.field);
      tests++;
      assert (obs === e.val) else begin
        failures++;
        $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    reset = 1'b1; aeoi = 1'b0; imr = 8'h00; vec_base = 5'b01000;
    irr = 8'h00; inta_n = 1'b1; eoi_valid = 1'b0; eoi_cmd = 3'b010; eoi_level = 3'd0;
    @(posedge clk);
    #1;

    // Reset state
    expectOut("rst_int", F_INT, 8'h00);
    expectOut("rst_clr", F_CLR, 8'h00);
    expectOut("rst_dout", F_DOUT, 8'h00);
    expectOut("rst_oe", F_OE, 8'h00);
    expectOut("rst_isr", F_ISR, 8'h00);
    applyStimulus(8'h00, 1'b1, 1'b0, 3'b010, 3'd0);
    checkOutput();
    reset = 1'b0;

    // Basic handshake: IR2 beats IR5 under fixed priority
    expectOut("req_int", F_INT, 8'h01);
    applyStimulus(8'h24, 1'b1, 1'b0, 3'b010, 3'd0);
    checkOutput();
    expectOut("ack1_isr", F_ISR, 8'h04);
    expectOut("ack1_clr", F_CLR, 8'h04);
    expectOut("ack1_int", F_INT, 8'h00);
    applyStimulus(8'h24, 1'b0, 1'b0, 3'b010, 3'd0);
    checkOutput();
    expectOut("clr_pulse_end", F_CLR, 8'h00);
    applyStimulus(8'h20, 1'b1, 1'b0, 3'b010, 3'd0);
    checkOutput();
    expectOut("ack2_dout", F_DOUT, 8'h42);
    expectOut("ack2_oe", F_OE, 8'h01);
    applyStimulus(8'h20, 1'b0, 1'b0, 3'b010, 3'd0);
    checkOutput();
    expectOut("exit_oe", F_OE, 8'h00);
    expectOut("exit_isr", F_ISR, 8'h04);
    applyStimulus(8'h20, 1'b1, 1'b0, 3'b010, 3'd0);
    checkOutput();

    // Fully nested: IR5 blocked by IR2 in service, IR1 allowed
    expectOut("nest_ir5", F_INT, 8'h00);
    applyStimulus(8'h20, 1'b1, 1'b0, 3'b010, 3'd0);
    checkOutput();
    expectOut("nest_ir1", F_INT, 8'h01);
    applyStimulus(8'h22, 1'b1, 1'b0, 3'b010, 3'd0);
    checkOutput();
    expectOut("nseoi_isr", F_ISR, 8'h00);
    applyStimulus(8'h22, 1'b1, 1'b1, 3'b001, 3'd0);
    checkOutput();
    applyStimulus(8'h00, 1'b1, 1'b0, 3'b010, 3'd0);

    // Rotate-specific EOI level 3 makes IR4 highest
    applyStimulus(8'h00, 1'b1, 1'b1, 3'b111, 3'd3);
    expectOut("rot_int", F_INT, 8'h01);
    applyStimulus(8'h11, 1'b1, 1'b0, 3'b010, 3'd0);
    checkOutput();
    expectOut("rot_isr", F_ISR, 8'h10);
    expectOut("rot_clr", F_CLR, 8'h10);
    applyStimulus(8'h11, 1'b0, 1'b0, 3'b010, 3'd0);
    checkOutput();
    applyStimulus(8'h01, 1'b1, 1'b0, 3'b010, 3'd0);
    expectOut("rot_dout", F_DOUT, 8'h44);
    expectOut("rot_oe", F_OE, 8'h01);
    applyStimulus(8'h01, 1'b0, 1'b0, 3'b010, 3'd0);
    checkOutput();
    expectOut("rot_exit_oe", F_OE, 8'h00);
    expectOut("rot_exit_isr", F_ISR, 8'h10);
    applyStimulus(8'h01, 1'b1, 1'b0, 3'b010, 3'd0);
    checkOutput();
    expectOut("rot_ir0_blocked", F_INT, 8'h00);
    applyStimulus(8'h01, 1'b1, 1'b0, 3'b010, 3'd0);
    checkOutput();
    expectOut("seoi_isr", F_ISR, 8'h00);
    applyStimulus(8'h00, 1'b1, 1'b1, 3'b011, 3'd4);
    checkOutput();

    // Automatic EOI on IR7
    aeoi = 1'b1;
    expectOut("aeoi_int", F_INT, 8'h01);
    applyStimulus(8'h80, 1'b1, 1'b0, 3'b010, 3'd0);
    checkOutput();
    expectOut("aeoi_isr_set", F_ISR, 8'h80);
    expectOut("aeoi_clr", F_CLR, 8'h80);
    applyStimulus(8'h80, 1'b0, 1'b0, 3'b010, 3'd0);
    checkOutput();
    applyStimulus(8'h00, 1'b1, 1'b0, 3'b010, 3'd0);
    expectOut("aeoi_dout", F_DOUT, 8'h47);
    expectOut("aeoi_oe", F_OE, 8'h01);
    applyStimulus(8'h00, 1'b0, 1'b0, 3'b010, 3'd0);
    checkOutput();
    expectOut("aeoi_exit_isr", F_ISR, 8'h00);
    expectOut("aeoi_exit_oe", F_OE, 8'h00);
    applyStimulus(8'h00, 1'b1, 1'b0, 3'b010, 3'd0);
    checkOutput();
    aeoi = 1'b0;

    // Spurious acknowledge
    vec_base = 5'b10101;
    expectOut("spur_idle_int", F_INT, 8'h00);
    applyStimulus(8'h00, 1'b1, 1'b0, 3'b010, 3'd0);
    checkOutput();
    expectOut("spur_isr", F_ISR, 8'h00);
    expectOut("spur_clr", F_CLR, 8'h00);
    expectOut("spur_int", F_INT, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0, 3'b010, 3'd0);
    checkOutput();
    applyStimulus(8'h00, 1'b1, 1'b0, 3'b010, 3'd0);
    expectOut("spur_dout", F_DOUT, 8'hAF);
    expectOut("spur_oe", F_OE, 8'h01);
    applyStimulus(8'h00, 1'b0, 1'b0, 3'b010, 3'd0);
    checkOutput();
    expectOut("spur_exit_oe", F_OE, 8'h00);
    expectOut("spur_exit_isr", F_ISR, 8'h00);
    applyStimulus(8'h00, 1'b1, 1'b0, 3'b010, 3'd0);
    checkOutput();

    // Reset while driving the vector in ACK2
    expectOut("mid_int", F_INT, 8'h01);
    applyStimulus(8'h01, 1'b1, 1'b0, 3'b010, 3'd0);
    checkOutput();
    expectOut("mid_isr", F_ISR, 8'h01);
    expectOut("mid_clr", F_CLR, 8'h01);
    applyStimulus(8'h01, 1'b0, 1'b0, 3'b010, 3'd0);
    checkOutput();
    applyStimulus(8'h00, 1'b1, 1'b0, 3'b010, 3'd0);
    expectOut("mid_dout", F_DOUT, 8'hA8);
    expectOut("mid_oe", F_OE, 8'h01);
    applyStimulus(8'h00, 1'b0, 1'b0, 3'b010, 3'd0);
    checkOutput();
    reset = 1'b1;
    expectOut("mid_rst_oe", F_OE, 8'h00);
    expectOut("mid_rst_isr", F_ISR, 8'h00);
    expectOut("mid_rst_int", F_INT, 8'h00);
    expectOut("mid_rst_dout", F_DOUT, 8'h00);
    expectOut("mid_rst_clr", F_CLR, 8'h00);
    applyStimulus(8'h01, 1'b0, 1'b0, 3'b010, 3'd0);
    checkOutput();
    reset = 1'b0;
    expectOut("post_rst_int", F_INT, 8'h01);
    applyStimulus(8'h01, 1'b1, 1'b0, 3'b010, 3'd0);
    checkOutput();
    expectOut("post_rst_isr", F_ISR, 8'h01);
    expectOut("post_rst_clr", F_CLR, 8'h01);
    applyStimulus(8'h01, 1'b0, 1'b0, 3'b010, 3'd0);
    checkOutput();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
